// File: rtl/falu_sequencer_if.sv
// falu_sequencer_if: request/response handshake and ALU drive bundle for the
// floating-point ALU sequencer. The slave modport is the sequencer's view; the
// master modport is the view of the issue logic and ALU that surround it.
`timescale 1ns/1ps

interface falu_sequencer_if;
    // Request port (issue logic -> sequencer)
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    // Response port (sequencer -> consumer)
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    // ALU drive and registered ALU result
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [9:0]  alu_en;
    logic [31:0] alu_data;

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, alu_data,
        output req_ready, resp_valid, resp_data, resp_err, alu_a, alu_b, alu_en
    );

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, alu_data,
        input  req_ready, resp_valid, resp_data, resp_err, alu_a, alu_b, alu_en
    );
endinterface

// File: rtl/falu_sequencer.sv
// falu_sequencer: single-issue controller for the floating-point ALU.
// Accepts one operation at a time, holds exactly one ALU enable for the
// operation's latency (1 cycle, DIV_LAT for divide, SQRT_LAT for sqrt),
// captures the ALU's registered result and returns it on the response port.
// Illegal opcodes (10..15) never enable the ALU and answer with resp_err=1.
// Optional feature macro: FALU_SEQ_B2B_EN -- lets a request be accepted in
// the same cycle as the response handshake, skipping the IDLE cycle.
`timescale 1ns/1ps

module falu_sequencer #(
    parameter int unsigned DIV_LAT  = 8,
    parameter int unsigned SQRT_LAT = 8
) (
    input  logic clk,
    input  logic rst_n,
    falu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SQRT = 4'd4;
    localparam logic [3:0] OP_LAST = 4'd9;

    // Opcodes 0..9 map to real ALU functions; the rest are rejected.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

    // Enable bit 9 is add (op 0) down to bit 0 for leq (op 9).
    function automatic logic [9:0] op_onehot(input logic [3:0] op);
        logic [9:0] oh;
        oh = '0;
        if (op_legal(op)) begin
            oh = 10'b10_0000_0000 >> op;
        end
        return oh;
    endfunction

    // Counter preload is latency minus one: EXEC lasts cnt+1 cycles.
    function automatic logic [7:0] op_cnt_init(input logic [3:0] op);
        logic [7:0] init;
        case (op)
            OP_DIV:  init = 8'(DIV_LAT - 1);
            OP_SQRT: init = 8'(SQRT_LAT - 1);
            default: init = 8'd0;
        endcase
        return init;
    endfunction

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  op_q, op_n;
    logic [31:0] opa_q, opa_n;
    logic [31:0] opb_q, opb_n;
    logic [9:0]  alu_en_q, alu_en_n;
    logic [31:0] resp_data_q, resp_data_n;
    logic        resp_err_q, resp_err_n;
    logic        req_ready;
    logic        accept;

    // Request acceptance: IDLE always; RESP too when back-to-back is built in,
    // but only in the cycle the consumer takes the current result.
    always_comb begin
        req_ready = (state == IDLE);
`ifdef FALU_SEQ_B2B_EN
        if (state == RESP) begin
            req_ready = bus.resp_ready;
        end
`endif
        accept = bus.req_valid && req_ready;
    end

    // Next-state and next-register values for the whole controller.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_n     = state;
        cnt_n       = cnt;
        op_n        = op_q;
        opa_n       = opa_q;
        opb_n       = opb_q;
        alu_en_n    = '0;
        resp_data_n = resp_data_q;
        resp_err_n  = resp_err_q;

        case (state)
            IDLE: begin
                // waiting; acceptance handled below
            end
            EXEC: begin
                if (cnt == 8'd0) begin
                    state_n = CAPT;
                end else begin
                    cnt_n    = cnt - 8'd1;
                    alu_en_n = op_onehot(op_q);
                end
            end
            CAPT: begin
                // ALU output register now holds the result of the last enable cycle
                resp_data_n = bus.alu_data;
                resp_err_n  = 1'b0;
                state_n     = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A new operation overrides whatever the current state decided; it can
        // only happen from IDLE or (back-to-back) from a completing RESP.
        if (accept) begin
            op_n  = bus.req_op;
            opa_n = bus.req_a;
            opb_n = bus.req_b;
            if (op_legal(bus.req_op)) begin
                cnt_n    = op_cnt_init(bus.req_op);
                alu_en_n = op_onehot(bus.req_op);
                state_n  = EXEC;
            end else begin
                cnt_n       = 8'd0;
                resp_data_n = 32'd0;
                resp_err_n  = 1'b1;
                state_n     = RESP;
            end
        end
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            op_q        <= 4'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            alu_en_q    <= '0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state       <= state_n;
            cnt         <= cnt_n;
            op_q        <= op_n;
            opa_q       <= opa_n;
            opb_q       <= opb_n;
            alu_en_q    <= alu_en_n;
            resp_data_q <= resp_data_n;
            resp_err_q  <= resp_err_n;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.alu_a      = opa_q;
    assign bus.alu_b      = opb_q;
    assign bus.alu_en     = alu_en_q;

    // The ALU enable bus must never carry more than one function.
    a_en_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(alu_en_q));

    // An enable is driven exactly while the controller is executing.
    a_en_exec: assert property (@(posedge clk) disable iff (!rst_n)
        ((alu_en_q != '0) == (state == EXEC)));

    // A stalled response keeps its payload.
    a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RESP && !bus.resp_ready) |=>
        (state == RESP && $stable(resp_data_q) && $stable(resp_err_q)));

endmodule

// File: tb/tb_falu_sequencer.sv
// tb_falu_sequencer: self-checking bench for falu_sequencer. A behavioural
// ALU model supplies results only when an enable is held for the full
// latency; expected latencies, enables and results come from opcode tables
// and real arithmetic inside the bench.
`timescale 1ns/1ps

module tb_falu_sequencer;

    localparam int unsigned DIV_LAT  = 8;
    localparam int unsigned SQRT_LAT = 8;

    logic clk;
    logic rst_n;

    falu_sequencer_if bus ();

    falu_sequencer #(
        .DIV_LAT  (DIV_LAT),
        .SQRT_LAT (SQRT_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic bit ref_legal(input logic [3:0] op);
        return op < 4'd10;
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        if (op == 4'd3) return int'(DIV_LAT);
        if (op == 4'd4) return int'(SQRT_LAT);
        if (op < 4'd10) return 1;
        return 0;
    endfunction

    function automatic logic [9:0] ref_onehot(input logic [3:0] op);
        logic [9:0] oh;
        oh = '0;
        if (op < 4'd10) oh[9 - int'(op)] = 1'b1;
        return oh;
    endfunction

    function automatic real s2r(input logic [31:0] s);
        logic [10:0] e;
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        d = {s[31], e, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        real ra;
        real rb;
        ra = s2r(a);
        rb = s2r(b);
        case (op)
            4'd0: return r2s(ra + rb);
            4'd1: return r2s(ra - rb);
            4'd2: return r2s(ra * rb);
            4'd3: return r2s(ra / rb);
            4'd4: return r2s($sqrt(ra));
            4'd5: return (ra >= rb) ? a : b;
            4'd6: return (ra <= rb) ? a : b;
            4'd7: return (ra == rb) ? 32'd1 : 32'd0;
            4'd8: return (ra <  rb) ? 32'd1 : 32'd0;
            4'd9: return (ra <= rb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- ALU model ----------------
    // Result appears in data_out only after the enable has been held for the
    // op's full latency; partial or idle cycles present poison values.
    int run = 0;
    always @(posedge clk) begin : alu_model
        logic [3:0] mop;
        mop = 4'd15;
        if ($onehot(bus.alu_en)) begin
            for (int i = 0; i < 10; i++) if (bus.alu_en[i]) mop = 4'(9 - i);
            run <= run + 1;
            if (run + 1 == ref_lat(mop)) bus.alu_data <= alu_fn(mop, bus.alu_a, bus.alu_b);
            else                         bus.alu_data <= 32'hDEAD0000 | 32'(run);
        end else begin
            run <= 0;
            bus.alu_data <= 32'hBAD0BAD0;
        end
    end

    // ---------------- transaction tasks (enter/leave at a negedge) ----------------
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int tries;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        tries = 0;
        while (bus.req_ready !== 1'b1 && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        check({tag, " req_ready seen"}, 32'(tries < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_op    = 4'($urandom);
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
    endtask

    // Starts in the first cycle after the accepting edge.
    task automatic observe(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_data, input logic exp_err, input string tag);
        int cyc, n_en, n_bad, n_opnd, lat;
        logic [9:0] oh;
        lat = ref_lat(op);
        oh  = ref_onehot(op);
        cyc = 0; n_en = 0; n_bad = 0; n_opnd = 0;
        while (bus.resp_valid !== 1'b1 && cyc < 600) begin
            if (oh != '0 && bus.alu_en === oh) n_en++;
            else if (bus.alu_en !== '0)        n_bad++;
            if (bus.alu_a !== a || bus.alu_b !== b) n_opnd++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " cycles to resp_valid"}, 32'(cyc), ref_legal(op) ? 32'(lat + 1) : 32'd0);
        check({tag, " enable cycles"}, 32'(n_en), 32'(lat));
        check({tag, " wrong enable cycles"}, 32'(n_bad), 32'd0);
        check({tag, " operand drift"}, 32'(n_opnd), 32'd0);
        check({tag, " resp_data"}, bus.resp_data, exp_data);
        check({tag, " resp_err"}, 32'(bus.resp_err), 32'(exp_err));
        check({tag, " alu_en in RESP"}, 32'(bus.alu_en), 32'd0);
        check({tag, " operands held"}, 32'((bus.alu_a === a) && (bus.alu_b === b)), 32'd1);
    endtask

    task automatic respond(input int hold, input logic [31:0] exp_data, input logic exp_err, input string tag);
        int n_unstable, n_bad;
        n_unstable = 0;
        n_bad = 0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_data || bus.resp_err !== exp_err) n_unstable++;
            if (bus.req_ready !== 1'b0 || bus.alu_en !== '0) n_bad++;
        end
        if (hold > 0) begin
            check({tag, " stalled resp unstable"}, 32'(n_unstable), 32'd0);
            check({tag, " stalled req_ready/en"}, 32'(n_bad), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check({tag, " resp_valid after handshake"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " req_ready after handshake"}, 32'(bus.req_ready), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    initial begin : main
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        int n_bad, n_bad2, n_resp;

        vecs[0]  = '{4'd0,  32'h3F800000, 32'h40000000, 0, 32'h40400000, 1'b0, "add"};
        vecs[1]  = '{4'd1,  32'h40400000, 32'h3F800000, 1, 32'h40000000, 1'b0, "sub"};
        vecs[2]  = '{4'd2,  32'h40000000, 32'h40400000, 0, 32'h40C00000, 1'b0, "mul"};
        vecs[3]  = '{4'd3,  32'h40C00000, 32'h40000000, 2, 32'h40400000, 1'b0, "div"};
        vecs[4]  = '{4'd4,  32'h40800000, 32'h00000000, 0, 32'h40000000, 1'b0, "sqrt"};
        vecs[5]  = '{4'd5,  32'h3F800000, 32'h40000000, 0, 32'h40000000, 1'b0, "max"};
        vecs[6]  = '{4'd6,  32'h3F800000, 32'h40000000, 0, 32'h3F800000, 1'b0, "min"};
        vecs[7]  = '{4'd7,  32'h40000000, 32'h40000000, 0, 32'h00000001, 1'b0, "eq"};
        vecs[8]  = '{4'd8,  32'h3F800000, 32'h40000000, 0, 32'h00000001, 1'b0, "lt"};
        vecs[9]  = '{4'd9,  32'h40000000, 32'h3F800000, 0, 32'h00000000, 1'b0, "leq"};
        vecs[10] = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 0, 32'h00000000, 1'b1, "illegal12"};
        vecs[11] = '{4'd15, 32'h3F800000, 32'h3F800000, 5, 32'h00000000, 1'b1, "illegal15"};
        vecs[12] = '{4'd5,  32'hBF800000, 32'h3F000000, 0, 32'h3F000000, 1'b0, "max neg"};

        bus.req_valid  = 1'b0;
        bus.req_op     = 4'd0;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.resp_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // reset values
        @(negedge clk);
        check("reset req_ready",  32'(bus.req_ready), 32'd1);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_data",  bus.resp_data, 32'd0);
        check("reset resp_err",   32'(bus.resp_err), 32'd0);
        check("reset alu_en",     32'(bus.alu_en), 32'd0);
        check("reset alu_a",      bus.alu_a, 32'd0);
        check("reset alu_b",      bus.alu_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].name);
            observe(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);
            respond(vecs[i].hold, vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);
        end

        // backpressure with a new request pending during RESP
        issue(4'd0, 32'h3F800000, 32'h40000000, "bp add");
        observe(4'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, "bp add");
        bus.req_valid = 1'b1;
        bus.req_op    = 4'd4;
        bus.req_a     = 32'h40800000;
        bus.req_b     = 32'h00000000;
        n_bad = 0;
        n_bad2 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h40400000 || bus.resp_err !== 1'b0) n_bad++;
            if (bus.req_ready !== 1'b0 || bus.alu_en !== '0) n_bad2++;
        end
        check("bp resp stable", 32'(n_bad), 32'd0);
        check("bp request held off", 32'(n_bad2), 32'd0);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
`ifdef FALU_SEQ_B2B_EN
        bus.req_valid = 1'b0;
        check("b2b sqrt enable", 32'(bus.alu_en), 32'(10'b0000100000));
        check("b2b resp_valid", 32'(bus.resp_valid), 32'd0);
`else
        check("bp no accept at handshake", 32'(bus.alu_en), 32'd0);
        check("bp req_ready in IDLE", 32'(bus.req_ready), 32'd1);
        check("bp resp_valid after handshake", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
`endif
        observe(4'd4, 32'h40800000, 32'h00000000, 32'h40000000, 1'b0, "bp sqrt");
        respond(0, 32'h40000000, 1'b0, "bp sqrt");

        // reset in the third EXEC cycle of a divide
        issue(4'd3, 32'h40C00000, 32'h40000000, "rst div");
        @(negedge clk);
        @(negedge clk);
        check("rst div running", 32'(bus.alu_en), 32'(10'b0001000000));
        #2 rst_n = 1'b0;
        #1;
        check("rst alu_en async", 32'(bus.alu_en), 32'd0);
        check("rst resp_valid async", 32'(bus.resp_valid), 32'd0);
        check("rst req_ready async", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || bus.alu_en !== '0) n_resp++;
        end
        check("rst no response", 32'(n_resp), 32'd0);
        check("rst req_ready after release", 32'(bus.req_ready), 32'd1);
        issue(4'd0, 32'h3F800000, 32'h40000000, "post-rst add");
        observe(4'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, "post-rst add");
        respond(1, 32'h40400000, 1'b0, "post-rst add");

        // randomized operations against the reference rules
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(15, 10));
            else                           op = 4'($urandom_range(9, 0));
            a = rand_fp();
            b = rand_fp();
            if (op == 4'd4) a[31] = 1'b0;
            exp = ref_legal(op) ? alu_fn(op, a, b) : 32'd0;
            issue(op, a, b, $sformatf("rnd%0d", i));
            observe(op, a, b, exp, !ref_legal(op), $sformatf("rnd%0d op%0d", i, op));
            respond($urandom_range(0, 3), exp, !ref_legal(op), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
